// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one usart_tx among N byte requesters, with
// packet locking and sequencing of the transmit/busy handshake.
module uart_tx_arbiter #(
    parameter int N             = 4,
    parameter int START_TIMEOUT = 65535
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   grant,
    output logic [7:0]     uart_data,
    output logic           uart_transmit,
    input  logic           uart_busy,
    output logic           timeout_err,
    input  logic           err_clear,
    output logic           idle
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(START_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t          state_reg;
    logic [IW-1:0]   ptr_reg;
    logic [IW-1:0]   owner_reg;
    logic            lock_reg;
    logic [CW-1:0]   cnt_reg;

    logic [7:0]      data_arr [N];
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_split
            assign data_arr[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IDX_MAX) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
        return N'(1) << i;
    endfunction

    // While a packet is open only its owner may be picked; otherwise scan
    // from the round-robin pointer and take the first valid requester.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = owner_reg;
        cand       = ptr_reg;
        if (lock_reg) begin
            pick_valid = req_valid[owner_reg];
        end else begin
            for (int off = 0; off < N; off++) begin
                if (!pick_valid && req_valid[cand]) begin
                    pick_valid = 1'b1;
                    pick_idx   = cand;
                end
                cand = next_idx(cand);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            lock_reg      <= 1'b0;
            cnt_reg       <= '0;
            grant         <= '0;
            req_ready     <= '0;
            uart_data     <= 8'h00;
            uart_transmit <= 1'b1;
            timeout_err   <= 1'b0;
            idle          <= 1'b1;
        end else begin
            req_ready <= '0;
            if (err_clear) begin
                timeout_err <= 1'b0;
            end
            case (state_reg)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant         <= onehot(pick_idx);
                        req_ready     <= onehot(pick_idx);
                        uart_data     <= data_arr[pick_idx];
                        uart_transmit <= 1'b0;
                        lock_reg      <= !req_last[pick_idx];
                        owner_reg     <= pick_idx;
                        if (req_last[pick_idx]) begin
                            ptr_reg <= next_idx(pick_idx);
                        end
                        cnt_reg   <= '0;
                        idle      <= 1'b0;
                        state_reg <= S_WAIT_START;
                    end else begin
                        idle <= !lock_reg;
                    end
                end
                S_WAIT_START: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    if (!uart_busy) begin
                        // Release transmit as soon as the frame starts so
                        // usart_tx does not wait for a re-arm afterwards.
                        uart_transmit <= 1'b1;
                        state_reg     <= S_WAIT_DONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        uart_transmit <= 1'b1;
                        timeout_err   <= 1'b1;
                        lock_reg      <= 1'b0;
                        grant         <= '0;
                        ptr_reg       <= next_idx(owner_reg);
                        state_reg     <= S_GAP;
                    end
                end
                S_WAIT_DONE: begin
                    if (uart_busy) begin
                        if (!lock_reg) begin
                            grant <= '0;
                        end
                        state_reg <= S_GAP;
                    end
                end
                S_GAP: begin
                    idle      <= !lock_reg;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
